// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_adder_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // New operands are only taken while no bits are being shifted.
    function automatic logic accepts_start(input state_t st, input logic start_req);
        return start_req && ((st == IDLE) || (st == DONE));
    endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// Single combinational 1-bit full adder cell driven by the serial controller.
module serial_fa_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);

    always_comb begin
        o_s    = i_a ^ i_b ^ i_cin;
        o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, WIDTH+1 cycles per add.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | one operand bit pair added per edge
// DONE  | result registered, done pulse; start here chains the next add
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_s_sh;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_c_out;
    logic             w_accept;
    logic             w_last;
    logic             w_fa_s;
    logic             w_fa_cout;

    serial_fa_cell u_fa (
        .i_a    (r_a_sh[0]),
        .i_b    (r_b_sh[0]),
        .i_cin  (r_carry),
        .o_s    (w_fa_s),
        .o_cout (w_fa_cout)
    );

    assign w_accept = accepts_start(r_state, start);
    assign w_last   = (r_state == SHIFT) && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = SHIFT;
            SHIFT:   if (w_last)   w_state_nxt = DONE;
            DONE:    w_state_nxt = w_accept ? SHIFT : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == SHIFT);
        done = (r_state == DONE);
    end

    // The counter is parked at zero on the final bit so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_s_sh  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_c_out <= 1'b0;
        end else if (w_accept) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_s_sh  <= '0;
            r_carry <= c_in;
            r_cnt   <= '0;
        end else if (r_state == SHIFT) begin
            r_a_sh  <= r_a_sh >> 1;
            r_b_sh  <= r_b_sh >> 1;
            r_s_sh  <= {w_fa_s, r_s_sh[WIDTH-1:1]};
            r_carry <= w_fa_cout;
            r_cnt   <= w_last ? '0 : r_cnt + CNT_W'(1);
            if (w_last) begin
                r_sum   <= {w_fa_s, r_s_sh[WIDTH-1:1]};
                r_c_out <= w_fa_cout;
            end
        end
    end

    assign sum   = r_sum;
    assign c_out = r_c_out;

`ifdef SERIAL_ADD_OVF_EN
    logic r_ovf;

    // On the last bit the carry flop holds the carry into the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= r_carry ^ w_fa_cout;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8) with a result scoreboard.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         c_in  = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int n_err = 0;
    int n_chk = 0;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } exp_t;

    exp_t sb[$];

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        logic [W:0] t;
        exp_t e;
        t   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        e.s = t[W-1:0];
        e.c = t[W];
        e.v = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after an edge; start is accepted on the next edge.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        a     = x;
        b     = y;
        c_in  = ci;
        start = 1'b1;
        sb.push_back(model(x, y, ci));
        step();
        start = 1'b0;
    endtask

    // Counts edges until done, bounded; also notes whether sum moved before done.
    task automatic wait_done(output int n, output logic held);
        logic [W-1:0] s0;
        s0   = sum;
        held = 1'b1;
        n    = 0;
        while (done !== 1'b1 && n < 4 * W) begin
            step();
            n++;
            if (done !== 1'b1 && sum !== s0) held = 1'b0;
        end
    endtask

    task automatic run_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                           input string nm);
        exp_t e;
        int   n;
        logic h;
        issue(x, y, ci);
        wait_done(n, h);
        n_chk++;
        if (n !== W) begin
            n_err++;
            $display("FAIL %s latency: got %0d edges expected %0d", nm, n, W);
        end
        n_chk++;
        if (h !== 1'b1) begin
            n_err++;
            $display("FAIL %s hold: sum changed before done (got 0 expected 1)", nm);
        end
        e = sb.pop_front();
        n_chk++;
        if (sum !== e.s) begin
            n_err++;
            $display("FAIL %s sum: got %h expected %h", nm, sum, e.s);
        end
        n_chk++;
        if (c_out !== e.c) begin
            n_err++;
            $display("FAIL %s c_out: got %b expected %b", nm, c_out, e.c);
        end
`ifdef SERIAL_ADD_OVF_EN
        n_chk++;
        if (ovf !== e.v) begin
            n_err++;
            $display("FAIL %s ovf: got %b expected %b", nm, ovf, e.v);
        end
`endif
        step();
        n_chk++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL %s done_pulse: got %b expected 0", nm, done);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({busy, done, sum, c_out} !== '0) begin
            n_err++;
            $display("FAIL reset outputs: got busy=%b done=%b sum=%h c_out=%b expected all 0",
                     busy, done, sum, c_out);
        end
`ifdef SERIAL_ADD_OVF_EN
        n_chk++;
        if (ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset ovf: got %b expected 0", ovf);
        end
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        run_add(8'h03, 8'h05, 1'b0, "basic_3p5");
        n_chk++;
        if (sum !== 8'h08 || c_out !== 1'b0) begin
            n_err++;
            $display("FAIL basic_literal: got %h/%b expected 08/0", sum, c_out);
        end
    endtask

    task automatic test_carry();
        run_add(8'hFF, 8'h01, 1'b0, "carry_ff_01");
        n_chk++;
        if (sum !== 8'h00 || c_out !== 1'b1) begin
            n_err++;
            $display("FAIL carry_literal1: got %h/%b expected 00/1", sum, c_out);
        end
        run_add(8'hFF, 8'hFF, 1'b1, "carry_ff_ff_1");
        n_chk++;
        if (sum !== 8'hFF || c_out !== 1'b1) begin
            n_err++;
            $display("FAIL carry_literal2: got %h/%b expected FF/1", sum, c_out);
        end
    endtask

    task automatic test_ignore_start();
        exp_t e;
        int   n;
        logic h;
        issue(8'h20, 8'h02, 1'b0);
        step();
        step();
        a     = 8'h11;
        b     = 8'h11;
        start = 1'b1;
        step();
        start = 1'b0;
        n_chk++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL ignore_busy: got %b expected 1", busy);
        end
        wait_done(n, h);
        n_chk++;
        if (n !== W - 3) begin
            n_err++;
            $display("FAIL ignore_latency: got %0d edges expected %0d", n, W - 3);
        end
        e = sb.pop_front();
        n_chk++;
        if (sum !== e.s || sum !== 8'h22) begin
            n_err++;
            $display("FAIL ignore_sum: got %h expected %h", sum, e.s);
        end
        step();
        n_chk++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL ignore_restart: got busy=%b done=%b expected 0/0", busy, done);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        issue(8'h40, 8'h04, 1'b1);
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        void'(sb.pop_front());
        n_chk++;
        if ({busy, done, sum, c_out} !== '0) begin
            n_err++;
            $display("FAIL midreset outputs: got busy=%b done=%b sum=%h c_out=%b expected all 0",
                     busy, done, sum, c_out);
        end
        step();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < W + 3; i++) begin
            step();
            if (done === 1'b1) seen++;
        end
        n_chk++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL midreset_no_done: got %0d done cycles expected 0", seen);
        end
        run_add(8'h12, 8'h34, 1'b1, "after_reset");
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   n1;
        int   n2;
        logic h;
        issue(8'h10, 8'h20, 1'b0);
        wait_done(n1, h);
        e = sb.pop_front();
        n_chk++;
        if (n1 !== W || sum !== e.s || c_out !== e.c) begin
            n_err++;
            $display("FAIL b2b_first: got n=%0d %h/%b expected n=%0d %h/%b",
                     n1, sum, c_out, W, e.s, e.c);
        end
        issue(8'h81, 8'h82, 1'b1);
        n_chk++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_no_idle: got busy=%b expected 1", busy);
        end
        wait_done(n2, h);
        n_chk++;
        if (n2 + 1 !== W + 1) begin
            n_err++;
            $display("FAIL b2b_spacing: got %0d cycles between dones expected %0d", n2 + 1, W + 1);
        end
        e = sb.pop_front();
        n_chk++;
        if (sum !== e.s || c_out !== e.c) begin
            n_err++;
            $display("FAIL b2b_second: got %h/%b expected %h/%b", sum, c_out, e.s, e.c);
        end
        step();
    endtask

    task automatic test_ovf();
        run_add(8'h7F, 8'h01, 1'b0, "ovf_7f_01");
`ifdef SERIAL_ADD_OVF_EN
        n_chk++;
        if (ovf !== 1'b1 || sum !== 8'h80) begin
            n_err++;
            $display("FAIL ovf_literal1: got ovf=%b sum=%h expected 1/80", ovf, sum);
        end
`endif
        run_add(8'hFF, 8'h01, 1'b0, "ovf_ff_01");
`ifdef SERIAL_ADD_OVF_EN
        n_chk++;
        if (ovf !== 1'b0 || c_out !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_literal2: got ovf=%b c_out=%b expected 0/1", ovf, c_out);
        end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 250; i++) begin
            run_add(W'($urandom), W'($urandom), 1'($urandom_range(1)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_ovf();
        test_random();
        n_chk++;
        if (sb.size() !== 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
